int_ctrl: RTL and testbench

Interrupt controller that drives the INT input of the risc core. It edge-detects up to NSRC peripheral request lines, holds them as pending, and applies a software-written mask. It presents the lowest-index enabled request to the core on INT/int_id, using an acknowledge / end-of-interrupt handshake. Software reaches the mask/pending/status registers through a small word-addressed register port driven from the data-memory decode.

---
 rtl/int_ctrl_pkg.sv | 12 +
 rtl/int_ctrl_if.sv | 16 +
 rtl/int_ctrl_prio_enc.sv | 14 +
 rtl/int_ctrl.sv | 64 ++++++
 tb/tb_int_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared FSM states, register map and status layout for int_ctrl
package int_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_PEND = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;
  localparam int S_BUSY = 31;
  localparam int S_INT = 30;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/int_ctrl_if.sv
// int_ctrl_if: register port and core interrupt handshake of int_ctrl
interface int_ctrl_if import int_ctrl_pkg::*; #(parameter int NSRC = 8, parameter int DATA_W = 32) ();
  localparam int ID_W = id_w(NSRC);
  logic              wr_en;
  logic              rd_en;
  logic [1:0]        addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              INT;
  logic              int_ack;
  logic              int_eoi;
  logic [ID_W-1:0]   int_id;
  logic              busy;
  modport master (output wr_en, rd_en, addr, wr_data, int_ack, int_eoi, input rd_data, INT, int_id, busy);
  modport slave (input wr_en, rd_en, addr, wr_data, int_ack, int_eoi, output rd_data, INT, int_id, busy);
endinterface

// File: rtl/int_ctrl_prio_enc.sv
// prio_enc: lowest-index-first priority encoder
module prio_enc #(parameter int NSRC = 8, parameter int ID_W = 3) (
  input  logic [NSRC-1:0] req,
  output logic [ID_W-1:0] idx,
  output logic            vld
);
  // scan downward so the lowest set index is the last one written
  always_comb begin
    idx = '0;
    vld = |req;
    for (int i = NSRC - 1; i >= 0; i--)
      if (req[i]) idx = ID_W'(i);
  end
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: edge-triggered, maskable, lowest-index-priority interrupt controller
module int_ctrl import int_ctrl_pkg::*; #(parameter int NSRC = 8, parameter int DATA_W = 32) (
  input logic            clk,
  input logic            rst,
  input logic [NSRC-1:0] irq_in,
  int_ctrl_if.slave      bus
);
  localparam int ID_W = id_w(NSRC);
  logic [NSRC-1:0]   mask_q, mask_d, pend_q, pend_d, prev_q, rise, clr;
  logic [DATA_W-1:0] rd_q, rd_d, stat;
  logic [ID_W-1:0]   id_q, id_d, enc_id;
  logic              enc_vld, ack, unused;
  state_t            state_q, state_d;
  assign ack = state_q == REQ && bus.int_ack;
  assign unused = ^bus.wr_data;
  prio_enc #(.NSRC(NSRC), .ID_W(ID_W)) u_enc (.req(pend_q & mask_q), .idx(enc_id), .vld(enc_vld));
  // register file next state; a new edge beats any clear of the same bit
  always_comb begin
    rise = irq_in & ~prev_q;
    clr = (bus.wr_en && bus.addr == A_PEND ? bus.wr_data[NSRC-1:0] : '0) | (ack ? NSRC'(1) << id_q : '0);
    mask_d = bus.wr_en && bus.addr == A_MASK ? bus.wr_data[NSRC-1:0] : mask_q;
    pend_d = (pend_q & ~clr) | rise;
    stat = DATA_W'(id_q);
    stat[S_BUSY] = state_q == SERVICE;
    stat[S_INT] = state_q == REQ;
    rd_d = !bus.rd_en ? rd_q : bus.addr == A_MASK ? DATA_W'(mask_q) : bus.addr == A_PEND ? DATA_W'(pend_q) : bus.addr == A_STAT ? stat : '0;
  end
  // request FSM; withdrawal looks at next-cycle eligibility so INT drops one cycle after the clearing write
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    case (state_q)
      IDLE: if (enc_vld) begin
        state_d = REQ;
        id_d = enc_id;
      end
      REQ: state_d = ack ? SERVICE : !(pend_d[id_q] && mask_d[id_q]) ? IDLE : REQ;
      SERVICE: state_d = bus.int_eoi ? IDLE : SERVICE;
      default: state_d = IDLE;
    endcase
  end
  // all state; irq_prev resets high so lines already high at release do not fire
  always_ff @(posedge clk) begin
    if (!rst) begin
      mask_q <= '0;
      pend_q <= '0;
      prev_q <= '1;
      state_q <= IDLE;
      id_q <= '0;
      rd_q <= '0;
    end else begin
      mask_q <= mask_d;
      pend_q <= pend_d;
      prev_q <= irq_in;
      state_q <= state_d;
      id_q <= id_d;
      rd_q <= rd_d;
    end
  end
  assign bus.rd_data = rd_q;
  assign bus.INT = state_q == REQ;
  assign bus.int_id = id_q;
  assign bus.busy = state_q == SERVICE;
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl
module tb_int_ctrl;
  import int_ctrl_pkg::*;
  logic       clk = 0;
  logic       rst = 0;
  logic [7:0] irq_in = 8'hFF;
  int         n_chk = 0;
  int         n_fail = 0;
  int_ctrl_if #(.NSRC(8)) bus ();
  int_ctrl #(.NSRC(8)) dut (.clk(clk), .rst(rst), .irq_in(irq_in), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.wr_en = 1;
    bus.addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en = 0;
  endtask

  task automatic rd(input logic [1:0] a);
    bus.rd_en = 1;
    bus.addr = a;
    tick();
    bus.rd_en = 0;
  endtask

  task automatic pulse_ack();
    bus.int_ack = 1;
    tick();
    bus.int_ack = 0;
  endtask

  task automatic pulse_eoi();
    bus.int_eoi = 1;
    tick();
    bus.int_eoi = 0;
  endtask

  initial begin
    bus.wr_en = 0;
    bus.rd_en = 0;
    bus.addr = 0;
    bus.wr_data = 0;
    bus.int_ack = 0;
    bus.int_eoi = 0;
    // reset with all lines high
    repeat (3) tick();
    chk("rst_int", 32'(bus.INT), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_id", 32'(bus.int_id), 0);
    chk("rst_rd", bus.rd_data, 0);
    rst = 1;
    repeat (10) tick();
    chk("held_high_int", 32'(bus.INT), 0);
    rd(A_PEND);
    chk("held_high_pend", bus.rd_data, 0);
    tick();
    chk("rd_hold", bus.rd_data, 0);
    // single request
    irq_in = 0;
    tick();
    wr(A_MASK, 32'h04);
    irq_in = 8'h04;
    tick();
    chk("t2_int_n", 32'(bus.INT), 0);
    irq_in = 0;
    tick();
    chk("t2_int_n1", 32'(bus.INT), 1);
    chk("t2_id", 32'(bus.int_id), 2);
    pulse_ack();
    chk("t2_ack_int", 32'(bus.INT), 0);
    chk("t2_ack_busy", 32'(bus.busy), 1);
    rd(A_PEND);
    chk("t2_pend", bus.rd_data, 0);
    rd(A_STAT);
    chk("t2_stat", bus.rd_data, 32'h8000_0002);
    pulse_eoi();
    chk("t2_eoi_busy", 32'(bus.busy), 0);
    chk("t2_eoi_int", 32'(bus.INT), 0);
    // priority
    wr(A_MASK, 32'hFF);
    irq_in = 8'h22;
    tick();
    irq_in = 0;
    tick();
    chk("t3_int", 32'(bus.INT), 1);
    chk("t3_id1", 32'(bus.int_id), 1);
    pulse_ack();
    chk("t3_busy", 32'(bus.busy), 1);
    pulse_eoi();
    chk("t3_idle", 32'(bus.INT), 0);
    tick();
    chk("t3_int5", 32'(bus.INT), 1);
    chk("t3_id5", 32'(bus.int_id), 5);
    rd(A_STAT);
    chk("t3_stat", bus.rd_data, 32'h4000_0005);
    pulse_ack();
    pulse_eoi();
    // read and write same register in one cycle returns old value
    bus.rd_en = 1;
    wr(A_MASK, 32'h00);
    bus.rd_en = 0;
    chk("rw_same", bus.rd_data, 32'hFF);
    rd(A_MASK);
    chk("mask_new", bus.rd_data, 0);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3);
    chk("addr3", bus.rd_data, 0);
    // masked source
    irq_in = 8'h08;
    tick();
    irq_in = 0;
    rd(A_PEND);
    chk("t4_pend", bus.rd_data, 32'h08);
    chk("t4_int0", 32'(bus.INT), 0);
    wr(A_MASK, 32'h0000_FF08);
    chk("t4_int_w", 32'(bus.INT), 0);
    tick();
    chk("t4_int", 32'(bus.INT), 1);
    chk("t4_id", 32'(bus.int_id), 3);
    rd(A_MASK);
    chk("t4_mask_upper", bus.rd_data, 32'h08);
    pulse_ack();
    pulse_eoi();
    // withdrawal by W1C
    wr(A_MASK, 32'h10);
    irq_in = 8'h10;
    tick();
    irq_in = 0;
    tick();
    chk("t5_int", 32'(bus.INT), 1);
    chk("t5_id", 32'(bus.int_id), 4);
    wr(A_PEND, 32'h10);
    chk("t5_withdraw", 32'(bus.INT), 0);
    rd(A_PEND);
    chk("t5_pend", bus.rd_data, 0);
    chk("t5_stay_idle", 32'(bus.INT), 0);
    // W1C racing a new edge: the set wins
    irq_in = 8'h10;
    tick();
    irq_in = 0;
    tick();
    chk("t5b_int", 32'(bus.INT), 1);
    irq_in = 8'h10;
    wr(A_PEND, 32'h10);
    irq_in = 0;
    rd(A_PEND);
    chk("t5b_pend", bus.rd_data, 32'h10);
    chk("t5b_int2", 32'(bus.INT), 1);
    chk("t5b_id", 32'(bus.int_id), 4);
    // stray handshakes
    pulse_eoi();
    chk("t6_eoi_req_int", 32'(bus.INT), 1);
    chk("t6_eoi_req_busy", 32'(bus.busy), 0);
    pulse_ack();
    chk("t6_svc", 32'(bus.busy), 1);
    pulse_eoi();
    pulse_ack();
    chk("t6_ack_idle_int", 32'(bus.INT), 0);
    chk("t6_ack_idle_busy", 32'(bus.busy), 0);
    // reset during service
    irq_in = 8'h10;
    tick();
    irq_in = 0;
    tick();
    pulse_ack();
    chk("t6_svc2", 32'(bus.busy), 1);
    rd(A_MASK);
    chk("t6_rd_pre", bus.rd_data, 32'h10);
    rst = 0;
    bus.int_eoi = 1;
    tick();
    bus.int_eoi = 0;
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_int", 32'(bus.INT), 0);
    chk("t6_rst_id", 32'(bus.int_id), 0);
    chk("t6_rst_rd", bus.rd_data, 0);
    rst = 1;
    rd(A_MASK);
    chk("t6_rst_mask", bus.rd_data, 0);
    rd(A_PEND);
    chk("t6_rst_pend", bus.rd_data, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
